next_pc_unit: RTL and testbench

//  Program-counter unit: holds the PC register and selects the next PC from

---
 rtl/next_pc_unit_pkg.sv | 18 +
 rtl/next_pc_unit_stat_counter.sv | 32 +++
 rtl/next_pc_unit.sv | 133 +++++++++++++
 tb/tb_next_pc_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/next_pc_unit_pkg.sv
// Shared definitions for the program-counter unit: next-PC select codes
// used by the select decode and by the controller.
package next_pc_unit_pkg;

   localparam int unsigned NPC_SEL_W = 3;

   localparam logic [NPC_SEL_W-1:0] NPC_HOLD = 3'd0;
   localparam logic [NPC_SEL_W-1:0] NPC_JR   = 3'd1;
   localparam logic [NPC_SEL_W-1:0] NPC_J    = 3'd2;
   localparam logic [NPC_SEL_W-1:0] NPC_BR   = 3'd3;
   localparam logic [NPC_SEL_W-1:0] NPC_SEQ  = 3'd4;

   // A selection that retires a jump instruction.
   function automatic logic is_jump_sel(input logic [NPC_SEL_W-1:0] sel);
      return (sel == NPC_JR) || (sel == NPC_J);
   endfunction

endpackage

// File: rtl/next_pc_unit_stat_counter.sv
// Free-running statistics counter with synchronous reset and count enable;
// wraps modulo 2^CNT_W.
module stat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             in_clk,
   input  logic             in_rst,
   input  logic             in_en,
   output logic [CNT_W-1:0] out_cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (in_en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign out_cnt = cnt_q;

endmodule

// File: rtl/next_pc_unit.sv
// Program-counter unit: PC register, prioritised next-PC select (hold, jump
// register, jump immediate, taken branch, sequential), sticky halt, run stats.
module next_pc_unit
   import next_pc_unit_pkg::*;
#(
   parameter int unsigned          ADDR_W   = 32,
   parameter int unsigned          JIDX_W   = 8,
   parameter int unsigned          BOFF_W   = 16,
   parameter int unsigned          INC      = 1,
   parameter logic [ADDR_W-1:0]    RESET_PC = '0,
   parameter int unsigned          CNT_W    = 32
) (
   input  logic              in_clk,
   input  logic              in_rst,
   input  logic              in_stall,
   input  logic              in_halt,
   input  logic              in_J,
   input  logic              in_JR,
   input  logic              in_br,
   input  logic              in_br_taken,
   input  logic [ADDR_W-1:0] in_a,
   input  logic [31:0]       in_is,
   output logic [ADDR_W-1:0] out_pc,
   output logic [ADDR_W-1:0] out_pcc,
   output logic              out_halted,
   output logic [CNT_W-1:0]  out_cyc_cnt,
   output logic [CNT_W-1:0]  out_j_cnt,
   output logic [CNT_W-1:0]  out_br_cnt
);

   logic [ADDR_W-1:0]    pc_q;
   logic [ADDR_W-1:0]    pc_d;
   logic                 halted_q;
   logic                 halted_d;

   logic [NPC_SEL_W-1:0] npc_sel;
   logic [ADDR_W-1:0]    pc_seq;
   logic [ADDR_W-1:0]    pc_jmp;
   logic [ADDR_W-1:0]    pc_br;
   logic [ADDR_W-1:0]    boff_ext;

   logic                 cyc_en;
   logic                 j_en;
   logic                 br_en;

   // Only the low JIDX_W / BOFF_W bits of the instruction feed this unit.
   logic                 unused_is_bits;
   assign unused_is_bits = ^in_is;

   always_comb begin
      npc_sel = NPC_SEQ;
      if (halted_q || in_stall) begin
         npc_sel = NPC_HOLD;
      end else if (in_halt) begin
         npc_sel = NPC_HOLD;
      end else if (in_J && in_JR) begin
         npc_sel = NPC_JR;
      end else if (in_J) begin
         npc_sel = NPC_J;
      end else if (in_br && in_br_taken) begin
         npc_sel = NPC_BR;
      end
   end

   always_comb begin
      pc_seq   = pc_q + ADDR_W'(INC);
      boff_ext = {{(ADDR_W-BOFF_W){in_is[BOFF_W-1]}}, in_is[BOFF_W-1:0]};
      pc_br    = pc_seq + boff_ext;
      pc_jmp   = {pc_q[ADDR_W-1:JIDX_W], in_is[JIDX_W-1:0]};
   end

   always_comb begin
      pc_d = pc_q;
      case (npc_sel)
         NPC_HOLD: pc_d = pc_q;
         NPC_JR:   pc_d = in_a;
         NPC_J:    pc_d = pc_jmp;
         NPC_BR:   pc_d = pc_br;
         NPC_SEQ:  pc_d = pc_seq;
         default:  pc_d = pc_q;
      endcase
   end

   // A stalled halt instruction is not latched; it will be seen again on release.
   always_comb begin
      halted_d = halted_q;
      if (!halted_q && !in_stall && in_halt) begin
         halted_d = 1'b1;
      end
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         pc_q     <= RESET_PC;
         halted_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         halted_q <= halted_d;
      end
   end

   always_comb begin
      cyc_en = !halted_q;
      j_en   = is_jump_sel(npc_sel);
      br_en  = (npc_sel == NPC_BR);
   end

   stat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
      .in_clk  (in_clk),
      .in_rst  (in_rst),
      .in_en   (cyc_en),
      .out_cnt (out_cyc_cnt)
   );

   stat_counter #(.CNT_W(CNT_W)) u_j_cnt (
      .in_clk  (in_clk),
      .in_rst  (in_rst),
      .in_en   (j_en),
      .out_cnt (out_j_cnt)
   );

   stat_counter #(.CNT_W(CNT_W)) u_br_cnt (
      .in_clk  (in_clk),
      .in_rst  (in_rst),
      .in_en   (br_en),
      .out_cnt (out_br_cnt)
   );

   assign out_pc     = pc_q;
   assign out_pcc    = pc_seq;
   assign out_halted = halted_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed self-checking bench for next_pc_unit, plus a CNT_W=4 instance
// for counter wrap.
module tb_next_pc_unit;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        halt;
   logic        j;
   logic        jr;
   logic        br;
   logic        br_taken;
   logic [31:0] a;
   logic [31:0] is;
   logic [31:0] pc;
   logic [31:0] pcc;
   logic        halted;
   logic [31:0] cyc_cnt;
   logic [31:0] j_cnt;
   logic [31:0] br_cnt;

   logic        rst4;
   logic [31:0] pc4;
   logic [31:0] pcc4;
   logic        halted4;
   logic [3:0]  cyc4;
   logic [3:0]  j4;
   logic [3:0]  br4;

   int unsigned checks;
   int unsigned errors;

   next_pc_unit u_dut (
      .in_clk      (clk),
      .in_rst      (rst),
      .in_stall    (stall),
      .in_halt     (halt),
      .in_J        (j),
      .in_JR       (jr),
      .in_br       (br),
      .in_br_taken (br_taken),
      .in_a        (a),
      .in_is       (is),
      .out_pc      (pc),
      .out_pcc     (pcc),
      .out_halted  (halted),
      .out_cyc_cnt (cyc_cnt),
      .out_j_cnt   (j_cnt),
      .out_br_cnt  (br_cnt)
   );

   next_pc_unit #(.CNT_W(4)) u_dut4 (
      .in_clk      (clk),
      .in_rst      (rst4),
      .in_stall    (1'b0),
      .in_halt     (1'b0),
      .in_J        (1'b0),
      .in_JR       (1'b0),
      .in_br       (1'b0),
      .in_br_taken (1'b0),
      .in_a        (32'h0),
      .in_is       (32'h0),
      .out_pc      (pc4),
      .out_pcc     (pcc4),
      .out_halted  (halted4),
      .out_cyc_cnt (cyc4),
      .out_j_cnt   (j4),
      .out_br_cnt  (br4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 0; halt = 0; j = 0; jr = 0; br = 0; br_taken = 0;
      a = '0; is = '0;
   endtask

   task automatic load_pc(input logic [31:0] val);
      idle();
      j = 1; jr = 1; a = val;
      step();
      idle();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      idle();
      rst  = 1;
      rst4 = 0;
      step();
      rst = 0;

      // Reset state
      check_eq("rst_pc", pc, 32'h0);
      check_eq("rst_pcc", pcc, 32'h1);
      check_eq("rst_halted", halted, 1'b0);
      check_eq("rst_cyc", cyc_cnt, 32'h0);
      check_eq("rst_j", j_cnt, 32'h0);
      check_eq("rst_br", br_cnt, 32'h0);

      // 1: sequential
      for (int i = 1; i <= 4; i++) begin
         step();
         check_eq("seq_pc", pc, 64'(i));
         check_eq("seq_pcc", pcc, 64'(i + 1));
      end
      check_eq("seq_cyc", cyc_cnt, 32'd4);
      check_eq("seq_j", j_cnt, 32'd0);
      check_eq("seq_br", br_cnt, 32'd0);

      // 2: jumps
      load_pc(32'h0000_1234);
      check_eq("jr_load", pc, 32'h0000_1234);
      j = 1; is = 32'h0000_0056;
      step();
      idle();
      check_eq("j_pc", pc, 32'h0000_1256);
      check_eq("j_cnt", j_cnt, 32'd2);
      j = 1; jr = 1; a = 32'h0000_0ABC;
      step();
      idle();
      check_eq("jr_pc", pc, 32'h0000_0ABC);
      check_eq("jr_cnt", j_cnt, 32'd3);
      check_eq("j_cyc", cyc_cnt, 32'd7);

      // 3: branches
      load_pc(32'h10);
      br = 1; br_taken = 1; is = 32'h0000_FFFC;
      step();
      idle();
      check_eq("br_pc", pc, 32'h0D);
      check_eq("br_cnt", br_cnt, 32'd1);
      load_pc(32'h10);
      br = 1; br_taken = 0; is = 32'h0000_FFFC;
      step();
      idle();
      check_eq("brnt_pc", pc, 32'h11);
      check_eq("brnt_cnt", br_cnt, 32'd1);
      j = 1; br = 1; br_taken = 1; is = 32'h0000_0040;
      step();
      idle();
      check_eq("jbr_pc", pc, 32'h40);
      check_eq("jbr_j", j_cnt, 32'd6);
      check_eq("jbr_br", br_cnt, 32'd1);
      jr = 1; a = 32'h999;
      step();
      idle();
      check_eq("jr_only_pc", pc, 32'h41);
      check_eq("jr_only_j", j_cnt, 32'd6);
      check_eq("br_cyc", cyc_cnt, 32'd13);

      // 4: stall
      for (int i = 0; i < 3; i++) begin
         stall = 1; j = 1; is = 32'h77; halt = (i == 1);
         step();
      end
      idle();
      check_eq("stall_pc", pc, 32'h41);
      check_eq("stall_j", j_cnt, 32'd6);
      check_eq("stall_cyc", cyc_cnt, 32'd16);
      check_eq("stall_halted", halted, 1'b0);

      // 5: halt
      load_pc(32'h20);
      halt = 1; j = 1; is = 32'h99;
      step();
      idle();
      check_eq("halt_flag", halted, 1'b1);
      check_eq("halt_pc", pc, 32'h20);
      check_eq("halt_cyc", cyc_cnt, 32'd18);
      check_eq("halt_j", j_cnt, 32'd7);
      for (int i = 0; i < 10; i++) begin
         j = i[0]; jr = i[1]; a = 32'h555; br = 1; br_taken = 1; is = 32'h4;
         step();
      end
      idle();
      check_eq("frz_pc", pc, 32'h20);
      check_eq("frz_halted", halted, 1'b1);
      check_eq("frz_cyc", cyc_cnt, 32'd18);
      check_eq("frz_j", j_cnt, 32'd7);
      check_eq("frz_br", br_cnt, 32'd1);
      rst = 1;
      step();
      rst = 0;
      check_eq("rst2_pc", pc, 32'h0);
      check_eq("rst2_halted", halted, 1'b0);
      check_eq("rst2_cyc", cyc_cnt, 32'h0);
      check_eq("rst2_j", j_cnt, 32'h0);
      check_eq("rst2_br", br_cnt, 32'h0);

      // 6: PC wrap and narrow counter wrap
      load_pc(32'hFFFF_FFFF);
      check_eq("wrap_pcc", pcc, 32'h0);
      step();
      check_eq("wrap_pc", pc, 32'h0);
      rst4 = 1;
      step();
      rst4 = 0;
      check_eq("c4_rst", cyc4, 4'd0);
      for (int i = 0; i < 17; i++) step();
      check_eq("c4_wrap", cyc4, 4'd1);
      check_eq("c4_pc", pc4, 32'h11);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
